// File: rtl/wb_redirect_stage.sv
// Writeback/redirect stage: selects rf write data, resolves branches/jumps, drives flush and counters.
// Latency: 1 cycle for all outputs. No backpressure: one instruction is accepted or squashed every cycle.
// Squashing: after a taken redirect the next FLUSH_CYCLES slots are squashed while flush_out is high.
module wb_redirect_stage #(
    parameter int DATA_W       = 32,
    parameter int REG_AW       = 6,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              n_in,
    input  logic              z_in,
    input  logic              mem_to_reg_in,
    input  logic              reg_wrt_in,
    input  logic              branch_z_in,
    input  logic              branch_n_in,
    input  logic              jump_in,
    input  logic              jump_mem_in,
    input  logic [DATA_W-1:0] mem_out_in,
    input  logic [DATA_W-1:0] alu_out_in,
    input  logic [REG_AW-1:0] rd_in,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pc_redirect,
    output logic [DATA_W-1:0] pc_target,
    output logic              flush_out,
    output logic [31:0]       retired_cnt,
    output logic [31:0]       squashed_cnt
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t      state, state_nxt;
    logic [3:0]  flush_cnt, flush_cnt_nxt;
    logic        commit, squash, taken;
    logic [DATA_W-1:0] target_sel;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            flush_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    // Next-state logic; squashed slots never reload the counter
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        case (state)
            IDLE: begin
                if (taken) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = 4'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                flush_cnt_nxt = flush_cnt - 4'd1;
                if (flush_cnt == 4'd1) state_nxt = IDLE;
            end
            default: begin
                state_nxt     = IDLE;
                flush_cnt_nxt = 4'd0;
            end
        endcase
    end

    // Output decode
    always_comb begin
        commit     = valid_in & (flush_cnt == 4'd0);
        squash     = valid_in & (flush_cnt != 4'd0);
        taken      = commit & ((branch_z_in & z_in) | (branch_n_in & n_in) | jump_in | jump_mem_in);
        target_sel = jump_mem_in ? mem_out_in : alu_out_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            pc_redirect  <= 1'b0;
            pc_target    <= '0;
            flush_out    <= 1'b0;
            retired_cnt  <= 32'd0;
            squashed_cnt <= 32'd0;
        end else begin
            rf_we        <= commit & reg_wrt_in;
            rf_waddr     <= rd_in;
            rf_wdata     <= mem_to_reg_in ? mem_out_in : alu_out_in;
            pc_redirect  <= taken;
            if (taken) pc_target <= target_sel;
            flush_out    <= (flush_cnt_nxt != 4'd0);
            retired_cnt  <= retired_cnt + 32'(commit);
            squashed_cnt <= squashed_cnt + 32'(squash);
        end
    end

endmodule

// File: tb/tb_wb_redirect_stage.sv
// Directed bench for wb_redirect_stage with hand-computed expectations.
module tb_wb_redirect_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, n_in, z_in, mem_to_reg_in, reg_wrt_in;
    logic        branch_z_in, branch_n_in, jump_in, jump_mem_in;
    logic [31:0] mem_out_in, alu_out_in;
    logic [5:0]  rd_in;
    logic        rf_we, pc_redirect, flush_out;
    logic [5:0]  rf_waddr;
    logic [31:0] rf_wdata, pc_target, retired_cnt, squashed_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    wb_redirect_stage #(.DATA_W(32), .REG_AW(6), .FLUSH_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .n_in(n_in), .z_in(z_in),
        .mem_to_reg_in(mem_to_reg_in), .reg_wrt_in(reg_wrt_in),
        .branch_z_in(branch_z_in), .branch_n_in(branch_n_in),
        .jump_in(jump_in), .jump_mem_in(jump_mem_in),
        .mem_out_in(mem_out_in), .alu_out_in(alu_out_in), .rd_in(rd_in),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pc_redirect(pc_redirect), .pc_target(pc_target), .flush_out(flush_out),
        .retired_cnt(retired_cnt), .squashed_cnt(squashed_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Flags: {valid, reg_wrt, mem_to_reg, branch_z, branch_n, jump, jump_mem, z, n}
    task automatic drive(input logic [8:0] f, input logic [31:0] mem, input logic [31:0] alu,
                         input logic [5:0] rd);
        {valid_in, reg_wrt_in, mem_to_reg_in, branch_z_in, branch_n_in,
         jump_in, jump_mem_in, z_in, n_in} = f;
        mem_out_in = mem;
        alu_out_in = alu;
        rd_in      = rd;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(9'b0, 32'h0, 32'h0, 6'd0);
        #12;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_redirect", 32'(pc_redirect), 32'd0);
        chk("rst_flush", 32'(flush_out), 32'd0);
        chk("rst_retired", retired_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU write
        drive(9'b110_0000_00, 32'h0, 32'h1234, 6'd5);
        cyc();
        chk("alu_we", 32'(rf_we), 32'd1);
        chk("alu_waddr", 32'(rf_waddr), 32'd5);
        chk("alu_wdata", rf_wdata, 32'h1234);
        chk("alu_redirect", 32'(pc_redirect), 32'd0);
        chk("alu_retired", retired_cnt, 32'd1);

        // Load write
        drive(9'b111_0000_00, 32'hDEADBEEF, 32'h10, 6'd63);
        cyc();
        chk("ld_wdata", rf_wdata, 32'hDEADBEEF);
        chk("ld_waddr", 32'(rf_waddr), 32'd63);

        // BRZ taken
        drive(9'b100_1000_10, 32'h0, 32'h40, 6'd0);
        cyc();
        chk("brz_redirect", 32'(pc_redirect), 32'd1);
        chk("brz_target", pc_target, 32'h40);
        chk("brz_flush", 32'(flush_out), 32'd1);
        chk("brz_we", 32'(rf_we), 32'd0);

        for (int i = 0; i < 3; i++) begin
            drive(9'b110_0000_00, 32'h0, 32'(i + 1), 6'd1);
            cyc();
            chk("sq_we", 32'(rf_we), 32'd0);
            chk("sq_redirect", 32'(pc_redirect), 32'd0);
            chk("sq_flush", 32'(flush_out), (i < 2) ? 32'd1 : 32'd0);
        end
        chk("sq_cnt", squashed_cnt, 32'd3);

        drive(9'b110_0000_00, 32'h0, 32'h99, 6'd7);
        cyc();
        chk("post_we", 32'(rf_we), 32'd1);
        chk("post_wdata", rf_wdata, 32'h99);
        chk("post_retired", retired_cnt, 32'd4);

        // BRN not taken
        drive(9'b100_0100_00, 32'h0, 32'h80, 6'd0);
        cyc();
        chk("brn_redirect", 32'(pc_redirect), 32'd0);
        chk("brn_flush", 32'(flush_out), 32'd0);
        chk("brn_target_hold", pc_target, 32'h40);
        chk("brn_retired", retired_cnt, 32'd5);

        // JM: memory target wins over ALU
        drive(9'b100_0001_00, 32'h200, 32'h55, 6'd0);
        cyc();
        chk("jm_redirect", 32'(pc_redirect), 32'd1);
        chk("jm_target", pc_target, 32'h200);

        // Idle cycles still count the flush down
        drive(9'b0, 32'h0, 32'h0, 6'd0);
        cyc();
        chk("pulse_1cyc", 32'(pc_redirect), 32'd0);
        cyc();
        chk("idle_flush", 32'(flush_out), 32'd1);

        // J in final flush slot is squashed
        drive(9'b100_0010_00, 32'h0, 32'h300, 6'd0);
        cyc();
        chk("jlast_redirect", 32'(pc_redirect), 32'd0);
        chk("jlast_target", pc_target, 32'h200);
        chk("jlast_sq", squashed_cnt, 32'd4);
        cyc();
        chk("jnext_redirect", 32'(pc_redirect), 32'd1);
        chk("jnext_target", pc_target, 32'h300);
        chk("jnext_flush", 32'(flush_out), 32'd1);
        chk("jnext_retired", retired_cnt, 32'd7);

        // Async reset mid-flush
        drive(9'b110_0000_00, 32'h0, 32'h66, 6'd3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_flush", 32'(flush_out), 32'd0);
        chk("arst_redirect", 32'(pc_redirect), 32'd0);
        chk("arst_target", pc_target, 32'd0);
        chk("arst_retired", retired_cnt, 32'd0);
        chk("arst_squashed", squashed_cnt, 32'd0);
        cyc();
        chk("arst_hold_we", 32'(rf_we), 32'd0);
        #3;
        rst_n = 1'b1;
        drive(9'b110_0000_00, 32'h0, 32'h77, 6'd9);
        cyc();
        chk("rel_we", 32'(rf_we), 32'd1);
        chk("rel_wdata", rf_wdata, 32'h77);
        chk("rel_waddr", 32'(rf_waddr), 32'd9);
        chk("rel_retired", retired_cnt, 32'd1);
        chk("rel_flush", 32'(flush_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
